// File: rtl/cache_axi_bridge.sv
`timescale 1ns/1ps
// cache_axi_bridge
//   Converts cache-side read and write requests into AXI3-style bursts.
//   A read FSM (R_IDLE/R_AR/R_DATA) and a write FSM (W_IDLE/W_AW/W_DATA/W_RESP)
//   run independently. Line accesses become 4-beat INCR bursts of 32-bit words;
//   byte/half/word accesses become single-beat transfers.
//
// Ports
//   clk, resetn                       clock, asynchronous active-low reset
//   rd_req/rd_type/rd_addr/rd_rdy     cache read request and acceptance
//   ret_valid/ret_last/ret_data       read return beats (pass-through of R)
//   wr_req/wr_type/wr_addr/wr_wstrb/
//   wr_data/wr_rdy                    cache write request and acceptance
//   ar*/r*/aw*/w*/b*                  AXI master channels (IDs constant AXI_ID)
module cache_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic         clk,
  input  logic         resetn,
  // cache read side
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  // cache write side
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  // AXI read address
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [1:0]   arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic         arvalid,
  input  logic         arready,
  // AXI read data
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  // AXI write address
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [1:0]   awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic         awvalid,
  input  logic         awready,
  // AXI write data
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  // AXI write response
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_e;

  localparam logic [2:0] TYPE_LINE  = 3'b100;
  localparam logic [1:0] BURST_INCR = 2'b01;

  function automatic logic [7:0] burst_len(input logic [2:0] t);
    return (t == TYPE_LINE) ? 8'd3 : 8'd0;
  endfunction

  function automatic logic [2:0] burst_size(input logic [2:0] t);
    return (t == TYPE_LINE) ? 3'd2 : {1'b0, t[1:0]};
  endfunction

  // Line bursts always start at the 16-byte line boundary.
  function automatic logic [31:0] burst_addr(input logic [31:0] a, input logic [2:0] t);
    return (t == TYPE_LINE) ? {a[31:4], 4'b0000} : a;
  endfunction

  rd_state_e      rd_state_q, rd_state_d;
  logic [31:0]    rd_addr_q,  rd_addr_d;
  logic [2:0]     rd_type_q,  rd_type_d;

  wr_state_e      wr_state_q, wr_state_d;
  logic [31:0]    wr_addr_q,  wr_addr_d;
  logic [2:0]     wr_type_q,  wr_type_d;
  logic [3:0]     wr_wstrb_q, wr_wstrb_d;
  logic [127:0]   wr_data_q,  wr_data_d;
  logic [1:0]     beat_q,     beat_d;

  logic           rd_hazard;
  logic           wr_last_beat;

  // rid/bid/rresp/bresp carry no information this bridge acts on.
  logic           unused_inputs;
  assign unused_inputs = ^{rid, rresp, bid, bresp};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_type_q  <= '0;
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_type_q  <= '0;
      wr_wstrb_q <= '0;
      wr_data_q  <= '0;
      beat_q     <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_type_q  <= rd_type_d;
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_type_q  <= wr_type_d;
      wr_wstrb_q <= wr_wstrb_d;
      wr_data_q  <= wr_data_d;
      beat_q     <= beat_d;
    end
  end

  // A read may not overtake a buffered write to the same 16-byte line. The
  // check uses the registered write state, so a write accepted in the same
  // cycle does not block the read.
  assign rd_hazard = (wr_state_q != W_IDLE) && (wr_addr_q[31:4] == rd_addr[31:4]);

  // Read FSM
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_type_d  = rd_type_q;
    rd_rdy     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        rd_rdy = resetn && !rd_hazard;
        if (rd_req && rd_rdy) begin
          rd_addr_d  = rd_addr;
          rd_type_d  = rd_type;
          rd_state_d = R_AR;
        end
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign araddr    = burst_addr(rd_addr_q, rd_type_q);
  assign arlen     = burst_len(rd_type_q);
  assign arsize    = burst_size(rd_type_q);
  assign arburst   = BURST_INCR;
  assign arid      = AXI_ID;
  assign arlock    = 2'b00;
  assign arcache   = 4'b0000;
  assign arprot    = 3'b000;

  assign ret_valid = rready && rvalid;
  assign ret_last  = rready && rvalid && rlast;
  assign ret_data  = rdata;

  assign wr_last_beat = (wr_type_q == TYPE_LINE) ? (beat_q == 2'd3) : (beat_q == 2'd0);

  // Write FSM; the buffer stays intact until the B response arrives.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_type_d  = wr_type_q;
    wr_wstrb_d = wr_wstrb_q;
    wr_data_d  = wr_data_q;
    beat_d     = beat_q;
    wr_rdy     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        wr_rdy = resetn;
        if (wr_req && wr_rdy) begin
          wr_addr_d  = wr_addr;
          wr_type_d  = wr_type;
          wr_wstrb_d = wr_wstrb;
          wr_data_d  = wr_data;
          beat_d     = 2'd0;
          wr_state_d = W_AW;
        end
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) wr_state_d = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wlast  = wr_last_beat;
        if (wready) begin
          if (wr_last_beat) begin
            beat_d     = 2'd0;
            wr_state_d = W_RESP;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign awaddr  = burst_addr(wr_addr_q, wr_type_q);
  assign awlen   = burst_len(wr_type_q);
  assign awsize  = burst_size(wr_type_q);
  assign awburst = BURST_INCR;
  assign awid    = AXI_ID;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  // Beat n carries wr_data[32n+31:32n].
  assign wid     = AXI_ID;
  assign wdata   = wr_data_q[{beat_q, 5'b00000} +: 32];
  assign wstrb   = (wr_type_q == TYPE_LINE) ? 4'hf : wr_wstrb_q;

endmodule

// File: tb/tb_cache_axi_bridge.sv
`timescale 1ns/1ps
module tb_cache_axi_bridge;

  localparam logic [3:0] ID = 4'd5;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rd_req = 1'b0;
  logic [2:0]   rd_type = '0;
  logic [31:0]  rd_addr = '0;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_type = '0;
  logic [31:0]  wr_addr = '0;
  logic [3:0]   wr_wstrb = '0;
  logic [127:0] wr_data = '0;
  logic         wr_rdy;
  logic [3:0]   arid, arcache, awid, awcache, wid, wstrb;
  logic [31:0]  araddr, awaddr, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, arprot, awsize, awprot;
  logic [1:0]   arburst, arlock, awburst, awlock;
  logic         arvalid, awvalid, wvalid, wlast, rready, bready;
  logic         arready = 1'b0, awready = 1'b0, wready = 1'b0;
  logic [3:0]   rid = 4'hA, bid = 4'hB;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = 2'b10, bresp = 2'b11;
  logic         rlast = 1'b0, rvalid = 1'b0, bvalid = 1'b0;

  cache_axi_bridge #(.AXI_ID(ID)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed { logic [31:0] data; logic last; } rbeat_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;

  rbeat_t rd_sb[$];
  wbeat_t wr_sb[$];
  int     ret_cnt = 0;

  // Output monitor: sampled on the falling edge, inputs change just after rising edge.
  always @(negedge clk) begin : mon
    rbeat_t rb;
    wbeat_t wb;
    if (resetn) begin
      if (wvalid) check("aw_w_overlap", awvalid, 1'b0);
      if (ret_valid) begin
        ret_cnt++;
        if (rd_sb.size() == 0) check("ret_unexpected", 1'b1, 1'b0);
        else begin
          rb = rd_sb.pop_front();
          check("ret_data", ret_data, rb.data);
          check("ret_last", ret_last, rb.last);
        end
      end
      if (wvalid && wready) begin
        if (wr_sb.size() == 0) check("w_unexpected", 1'b1, 1'b0);
        else begin
          wb = wr_sb.pop_front();
          check("wdata", wdata, wb.data);
          check("wstrb", wstrb, wb.strb);
          check("wlast", wlast, wb.last);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_write(input logic [2:0] t, input logic [3:0] s, input logic [127:0] d);
    int n;
    n = (t == 3'b100) ? 4 : 1;
    for (int i = 0; i < n; i++)
      wr_sb.push_back('{data: d[32*i +: 32], strb: (t == 3'b100) ? 4'hf : s, last: (i == n - 1)});
  endtask

  task automatic rd_issue(input logic [31:0] a, input logic [2:0] t);
    int k;
    rd_req = 1'b1; rd_addr = a; rd_type = t; k = 0;
    @(negedge clk);
    while (!rd_rdy && k < 50) begin @(negedge clk); k++; end
    check("rd_accept", rd_rdy, 1'b1);
    @(posedge clk); #1 rd_req = 1'b0;
  endtask

  task automatic wr_issue(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s,
                          input logic [127:0] d);
    int k;
    wr_req = 1'b1; wr_addr = a; wr_type = t; wr_wstrb = s; wr_data = d; k = 0;
    @(negedge clk);
    while (!wr_rdy && k < 50) begin @(negedge clk); k++; end
    check("wr_accept", wr_rdy, 1'b1);
    push_write(t, s, d);
    @(posedge clk); #1 wr_req = 1'b0;
  endtask

  task automatic ar_hs(input int dly);
    repeat (dly) tick();
    arready = 1'b1; tick(); arready = 1'b0;
  endtask

  task automatic aw_hs(input int dly);
    repeat (dly) tick();
    awready = 1'b1; tick(); awready = 1'b0;
  endtask

  task automatic r_beats(input int n, input logic [31:0] base, input bit gap);
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1; rdata = base + i; rlast = (i == n - 1);
      rd_sb.push_back('{data: base + i, last: (i == n - 1)});
      tick();
      rvalid = 1'b0; rlast = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic w_drain(input bit toggle);
    int k;
    k = 0;
    while (wr_sb.size() > 0 && k < 40) begin
      wready = toggle ? k[0] : 1'b1;
      tick(); k++;
    end
    wready = 1'b0;
    check("w_drain_done", wr_sb.size(), 0);
  endtask

  task automatic b_hs();
    bvalid = 1'b1; tick(); bvalid = 1'b0;
  endtask

  initial begin : stim
    int snap;
    // reset state
    #2;
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid",  wvalid,  1'b0);
    check("rst_rready",  rready,  1'b0);
    check("rst_bready",  bready,  1'b0);
    check("rst_retvalid", ret_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rel_rd_rdy", rd_rdy, 1'b1);
    check("rel_wr_rdy", wr_rdy, 1'b1);
    check("ids", {arid, awid, wid}, {ID, ID, ID});
    check("ar_consts", {arlock, arcache, arprot}, 9'd0);
    check("aw_consts", {awlock, awcache, awprot}, 9'd0);
    tick();

    // line read, AR accepted after two waiting cycles, beats with gaps
    rd_issue(32'h1C00_0010, 3'b100);
    @(negedge clk);
    check("lr_arvalid", arvalid, 1'b1);
    check("lr_araddr", araddr, 32'h1C00_0010);
    check("lr_arlen", arlen, 8'd3);
    check("lr_arsize", arsize, 3'd2);
    check("lr_arburst", arburst, 2'b01);
    check("lr_rready_early", rready, 1'b0);
    check("lr_rd_rdy_busy", rd_rdy, 1'b0);
    tick();
    ar_hs(1);
    @(negedge clk);
    check("lr_arvalid_drop", arvalid, 1'b0);
    check("lr_rready", rready, 1'b1);
    tick();
    snap = ret_cnt;
    r_beats(4, 32'hA000_0000, 1'b1);
    check("lr_ret_count", ret_cnt - snap, 4);

    // word read
    rd_issue(32'h1C00_0008, 3'b010);
    @(negedge clk);
    check("wd_araddr", araddr, 32'h1C00_0008);
    check("wd_arlen", arlen, 8'd0);
    check("wd_arsize", arsize, 3'd2);
    tick();
    ar_hs(0);
    r_beats(1, 32'hBEEF_0001, 1'b0);
    @(negedge clk);
    check("wd_rd_rdy_after", rd_rdy, 1'b1);
    tick();

    // line write with toggling wready
    wr_issue(32'h1C00_0020, 3'b100, 4'h3, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    @(negedge clk);
    check("lw_awvalid", awvalid, 1'b1);
    check("lw_awaddr", awaddr, 32'h1C00_0020);
    check("lw_awlen", awlen, 8'd3);
    check("lw_awsize", awsize, 3'd2);
    check("lw_awburst", awburst, 2'b01);
    check("lw_wvalid_before_aw", wvalid, 1'b0);
    check("lw_wr_rdy_busy", wr_rdy, 1'b0);
    tick();
    aw_hs(1);
    w_drain(1'b1);
    @(negedge clk);
    check("lw_bready", bready, 1'b1);
    check("lw_wr_rdy_resp", wr_rdy, 1'b0);
    tick();
    bvalid = 1'b1;
    @(negedge clk);
    check("lw_wr_rdy_bvalid", wr_rdy, 1'b0);
    tick(); bvalid = 1'b0;
    @(negedge clk);
    check("lw_wr_rdy_done", wr_rdy, 1'b1);
    tick();

    // read-after-write hazard, plus a non-conflicting read
    wr_issue(32'h1C00_0020, 3'b010, 4'b0110, 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D);
    rd_req = 1'b1; rd_addr = 32'h1C00_002C; rd_type = 3'b010;
    @(negedge clk);
    check("hz_block_aw", rd_rdy, 1'b0);
    tick();
    rd_addr = 32'h1C00_0040;
    @(negedge clk);
    check("hz_other_line", rd_rdy, 1'b1);
    @(posedge clk); #1 rd_req = 1'b0;
    ar_hs(0);
    r_beats(1, 32'h4040_4040, 1'b0);
    rd_req = 1'b1; rd_addr = 32'h1C00_002C;
    @(negedge clk);
    check("hz_block_again", rd_rdy, 1'b0);
    tick();
    aw_hs(0);
    w_drain(1'b0);
    @(negedge clk);
    check("hz_block_resp", rd_rdy, 1'b0);
    tick();
    bvalid = 1'b1;
    @(negedge clk);
    check("hz_block_bvalid", rd_rdy, 1'b0);
    tick(); bvalid = 1'b0;
    @(negedge clk);
    check("hz_release", rd_rdy, 1'b1);
    @(posedge clk); #1 rd_req = 1'b0;
    @(negedge clk);
    check("hz_araddr", araddr, 32'h1C00_002C);
    tick();
    ar_hs(0);
    r_beats(1, 32'h2C2C_2C2C, 1'b0);

    // simultaneous read and write to the same line: both accepted
    rd_req = 1'b1; rd_addr = 32'h1C00_0050; rd_type = 3'b010;
    wr_req = 1'b1; wr_addr = 32'h1C00_0054; wr_type = 3'b010; wr_wstrb = 4'hc;
    wr_data = 128'h0000_0000_0000_0000_0000_0000_1234_5678;
    @(negedge clk);
    check("sim_rd_rdy", rd_rdy, 1'b1);
    check("sim_wr_rdy", wr_rdy, 1'b1);
    push_write(3'b010, 4'hc, 128'h1234_5678);
    @(posedge clk); #1 rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    check("sim_arvalid", arvalid, 1'b1);
    check("sim_awvalid", awvalid, 1'b1);
    tick();
    ar_hs(0);
    r_beats(1, 32'h5050_5050, 1'b0);
    aw_hs(0);
    w_drain(1'b0);
    b_hs();

    // reset pulse during beat 2 of a line write
    wr_issue(32'h1C00_0060, 3'b100, 4'h0, 128'hDDDD_0003_CCCC_0002_BBBB_0001_AAAA_0000);
    aw_hs(0);
    wready = 1'b1;
    tick(); tick();
    check("pre_rst_wvalid", wvalid, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_wvalid", wvalid, 1'b0);
    check("rst_mid_awvalid", awvalid, 1'b0);
    check("rst_mid_arvalid", arvalid, 1'b0);
    wready = 1'b0;
    wr_sb.delete();
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    check("post_rst_wr_rdy", wr_rdy, 1'b1);
    check("post_rst_rd_rdy", rd_rdy, 1'b1);
    check("post_rst_wvalid", wvalid, 1'b0);
    tick();
    wr_issue(32'h1C00_0070, 3'b100, 4'h0, 128'h8888_8888_7777_7777_6666_6666_5555_5555);
    aw_hs(0);
    w_drain(1'b0);
    b_hs();

    repeat (2) tick();
    check("rd_sb_empty", rd_sb.size(), 0);
    check("wr_sb_empty", wr_sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
